// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed N-digit hex seven-segment driver. A shadow register takes
//   value on load. The display buffer copies the shadow only at a frame
//   boundary, so a frame is never drawn from two different values. The
//   digits share one segment bus, and each digit is driven in turn.
//   The first cycle of every digit slot is dead time, with all anodes off,
//   to avoid ghosting. All outputs are registered and show the
//   scan state of the previous cycle.
// Ports
//   clk, reset_n   : clock (rising edge), async active-low reset. The release
//                    is expected to be synchronous to clk.
//   value, load    : hex nibbles (digit 0 rightmost) and capture strobe
//   digit_en       : per-digit enable, sampled live
//   blink          : per-digit blink request, sampled live
//   lz_blank       : leading-zero suppression, sampled live
//   segments       : g..a, bit 0 = a, polarity set by SEG_ACTIVE_LOW
//   anodes         : per-digit drive, polarity set by AN_ACTIVE_LOW
//   frame_tick     : 1-cycle pulse on the first output cycle of each frame
//                    after the initial one
module seg_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_DIV      = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_blank,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_tick
);
  localparam int PW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_DIV - 1);
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]           p;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           fcnt;
  logic                    blink_phase;
  logic                    started;      // set once the first frame wraps
  logic [4*NUM_DIGITS-1:0] shadow, buffer;

  // Active-high hex glyphs, g..a.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // hi_zero[k]: nibble k and every higher nibble are zero.
  logic [NUM_DIGITS-1:0] hi_zero, lit;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic nz;
    assign nz = (buffer[4*k +: 4] == 4'h0);
    if (k == NUM_DIGITS - 1) begin : g_top
      assign hi_zero[k] = nz;
    end else begin : g_low
      assign hi_zero[k] = nz & hi_zero[k+1];
    end
    // Digit 0 is never blanked as a leading zero, so a value of 0 still shows "0".
    assign lit[k] = digit_en[k] & ~(blink[k] & blink_phase)
                  & ~(lz_blank & hi_zero[k] & (k != 0));
  end

  logic slot_end, frame_end;
  logic [6:0] seg_on;
  assign slot_end  = (p == P_LAST);
  assign frame_end = slot_end && (idx == I_LAST);
  assign seg_on    = glyph(buffer[4*idx +: 4]) ^ SEG_OFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p           <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      started     <= 1'b0;
      shadow      <= '0;
      buffer      <= '0;
      segments    <= SEG_OFF;
      anodes      <= AN_OFF;
      frame_tick  <= 1'b0;
    end else begin
      if (load) shadow <= value;
      p <= slot_end ? '0 : p + 1'b1;
      if (slot_end) idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
      if (frame_end) begin
        // A load on the boundary edge goes straight into the new frame.
        buffer  <= load ? value : shadow;
        started <= 1'b1;
        if (fcnt == F_LAST) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      frame_tick <= (p == '0) && (idx == '0) && started;
      if (p == '0) begin
        segments <= SEG_OFF;
        anodes   <= AN_OFF;
      end else begin
        anodes   <= AN_OFF ^ (NUM_DIGITS'(1) << idx);
        segments <= lit[idx] ? seg_on : SEG_OFF;
      end
    end
  end
endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Multiplexed, parametrised seven-segment display driver: latches an N-digit hex value and time-multiplexes it onto one shared segment bus plus per-digit anode enables. Adds per-digit enable, per-digit blink, leading-zero blanking, anti-ghosting dead time and tear-free frame-synchronous update. Sits between status/result registers (e.g. PUF response readout) and the board's common-segment display pins. Uses the standard hex glyph set (0-9, A-F, segment order g..a, bit 0 = a).

## Interface
- NUM_DIGITS, 4, number of digits; range 1..8
- CLK_DIV, 50000, clock cycles per digit slot; must be >= 2
- BLINK_DIV, 64, frames per blink half-period; must be >= 1
- SEG_ACTIVE_LOW, 1, 1 = segment lit when pin is 0
- AN_ACTIVE_LOW, 1, 1 = digit enabled when anode pin is 0

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost
- load  in  1  capture value into shadow register this cycle
- digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit dark
- blink  in  NUM_DIGITS  per-digit blink request
- lz_blank  in  1  suppress leading zeros
- segments  out  7  segment drive, polarity per SEG_ACTIVE_LOW
- anodes  out  NUM_DIGITS  digit drive, polarity per AN_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse at start of each scan frame

## Operation
- Shadow register: loaded from value on any cycle with load=1.
- Display buffer: updated only at frame boundary (digit index wrap NUM_DIGITS-1 -> 0). If load=1 on the boundary edge, value is forwarded directly into the buffer.
- Prescaler p: 0..CLK_DIV-1, increments every cycle; at CLK_DIV-1 wraps to 0 and digit index idx advances (wraps NUM_DIGITS-1 -> 0).
- Blink: frame counter 0..BLINK_DIV-1; on wrap, blink_phase toggles. Digit k dark when blink[k]=1 and blink_phase=1.
- Leading-zero blanking (lz_blank=1): digit k dark if its nibble and every higher-index nibble are 0; digit 0 never blanked by this rule (value 0 shows "0").
- Digit k lit iff digit_en[k]=1, not blink-dark, not LZ-blanked. Dark digit: anode still active, segments all off.
- Dead time: in slot cycle p=0 all anodes inactive and segments off.
- Otherwise anode[idx] active only; segments = glyph of buffer nibble idx.
- digit_en, blink, lz_blank are sampled live (not buffered).

## Timing
- All outputs registered; outputs reflect (idx, p, buffer, controls) of the previous cycle: one-cycle latency.
- Reset (async assert, sync-clean release): p=0, idx=0, frame counter=0, blink_phase=0, shadow=0, buffer=0; segments all off, anodes all inactive, frame_tick=0.
- First post-reset cycle is p=0 of digit 0 (dead time); digit 0 first drives on the 2nd output cycle.
- frame_tick high for exactly one cycle, in the output cycle corresponding to p=0, idx=0 (i.e. the cycle after the wrap edge); not asserted for the initial post-reset frame.
- Frame period = NUM_DIGITS*CLK_DIV cycles; blink period = 2*BLINK_DIV frames.
- New value visible no earlier than the next frame boundary; never mid-frame (no tearing).
- Reset mid-frame: all state returns to reset values immediately; load in progress discarded.
- NUM_DIGITS=1: idx stays 0, every slot end is a frame boundary.

## Test plan
- Reset/scan (NUM_DIGITS=4, CLK_DIV=4, active-low): after reset_n rises, outputs: 1 dead cycle, anodes=4'b1110 for 3 cycles, dead, 4'b1101 x3, ... ; frame_tick pulse every 16 cycles from cycle 16.
- Glyphs: load 16'h1A3F, wait one frame -> segments per slot: digit0 7'b0001110, digit1 7'b0110000, digit2 7'b0001000, digit3 7'b1111001.
- Tear-free: load 16'h0000 then 16'h8888 mid-frame at digit 1 -> digits 2,3 keep old value this frame; all show 7'b0000000 from next frame; load on boundary edge shows new value that frame.
- LZ blanking: value 16'h0050, lz_blank=1 -> digits 3,2 segments 7'b1111111, digit1 7'b0010010, digit0 7'b1000000; value 0 -> only digit0 shows 7'b1000000.
- Blink/enable: BLINK_DIV=2, blink=4'b0001, digit_en=4'b1011 -> digit2 always dark; digit0 lit frames 0-1, dark 2-3, lit 4-5.
- Async reset mid-frame at idx=2, p=3 -> same-cycle outputs off, frame_tick 0, counters restart from idx 0.
